mc_control_hs: RTL and testbench

- Parametrised successor to the multicycle CPU `Control` FSM; sits between the instruction register and the datapath muxes, register file, ALU and memory.
- Adds a memory request/ready handshake and an illegal-opcode trap.
- Adds an explicit branch-condition select (EQ/NE/LT) and instruction-retire and state-observation outputs.
- Outputs are Moore-style: decoded from state, gated by `mem_ready` on memory states.

---
 rtl/mc_control_hs.sv | 189 ++++++++++++++++++
 tb/tb_mc_control_hs.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_hs.sv
// Multicycle CPU control FSM with memory request/ready handshake, an
// illegal-opcode trap, branch-condition select and retire/state observation.
// Outputs are Moore-style, decoded from state and gated by mem_ready in memory states.
module mc_control_hs #(
   parameter int unsigned OPW     = 6,
   parameter int unsigned MEM_HS  = 1,
   parameter int unsigned TRAP_EN = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_ready,
   output logic           mem_req,
   output logic           PCWrite,
   output logic           PCWriteCond,
   output logic [1:0]     cond_sel,
   output logic           MemWrite,
   output logic           MemtoReg,
   output logic           IRWrite,
   output logic [1:0]     PCSource,
   output logic [1:0]     ALUOp,
   output logic [1:0]     ALUSrcA,
   output logic [1:0]     ALUSrcB,
   output logic           RegWrite,
   output logic [1:0]     RegSelect2,
   output logic           illegal,
   output logic           instr_done,
   output logic [3:0]     state
);

   typedef enum logic [3:0] {
      S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
      S_EXEC_LUI = 4'd4, S_BRANCH = 4'd5, S_JUMP = 4'd6,   S_ADDR = 4'd7,
      S_MEM_RD = 4'd8, S_MEM_WR = 4'd9,  S_WB_ALU = 4'd10, S_WB_MEM = 4'd11,
      S_TRAP = 4'd12
   } state_t;

   typedef enum logic [3:0] {
      C_NOOP, C_J, C_BEQ, C_BNE, C_BLT, C_R, C_I, C_LUI,
      C_LW, C_SW, C_LWI, C_SWI, C_ILL
   } cls_t;

   state_t state_q, state_d;
   cls_t   dec_c, cls_q;
   logic   rdy_c;

   // With the handshake disabled memory always completes in one cycle
   assign rdy_c = (MEM_HS != 0) ? mem_ready : 1'b1;
   assign state = state_q;

   // Opcode decode into an instruction class
   always_comb begin
      dec_c = C_ILL;
      if      (opcode == OPW'(6'b000000)) dec_c = C_NOOP;
      else if (opcode == OPW'(6'b000001)) dec_c = C_J;
      else if (opcode == OPW'(6'b100000)) dec_c = C_BEQ;
      else if (opcode == OPW'(6'b100001)) dec_c = C_BNE;
      else if (opcode == OPW'(6'b100010)) dec_c = C_BLT;
      else if (opcode == OPW'(6'b010101)) dec_c = C_R;
      else if (opcode == OPW'(6'b110010)) dec_c = C_I;
      else if (opcode == OPW'(6'b111010)) dec_c = C_LUI;
      else if (opcode == OPW'(6'b111101)) dec_c = C_LW;
      else if (opcode == OPW'(6'b111110)) dec_c = C_SW;
      else if (opcode == OPW'(6'b111011)) dec_c = C_LWI;
      else if (opcode == OPW'(6'b111100)) dec_c = C_SWI;
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Instruction class captured on DECODE exit so opcode may change afterwards
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                    cls_q <= C_NOOP;
      else if (state_q == S_DECODE)  cls_q <= dec_c;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (rdy_c) state_d = S_DECODE;
         S_DECODE: begin
            case (dec_c)
               C_NOOP:                     state_d = S_FETCH;
               C_J:                        state_d = S_JUMP;
               C_BEQ, C_BNE, C_BLT:        state_d = S_BRANCH;
               C_R:                        state_d = S_EXEC_R;
               C_I:                        state_d = S_EXEC_I;
               C_LUI:                      state_d = S_EXEC_LUI;
               C_LW, C_SW, C_LWI, C_SWI:   state_d = S_ADDR;
               default:                    state_d = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
            endcase
         end
         S_EXEC_R, S_EXEC_I, S_EXEC_LUI:  state_d = S_WB_ALU;
         S_ADDR:   state_d = (cls_q == C_LW || cls_q == C_LWI) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (rdy_c) state_d = S_WB_MEM;
         S_MEM_WR: if (rdy_c) state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // Moore output decode; everything held low while reset is asserted
   always_comb begin
      mem_req     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      cond_sel    = 2'b00;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      RegWrite    = 1'b0;
      RegSelect2  = 2'b00;
      illegal     = 1'b0;
      instr_done  = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = rdy_c;
               PCWrite = rdy_c;
            end
            S_DECODE: begin
               ALUSrcB    = 2'b10;
               instr_done = (dec_c == C_NOOP) || (dec_c == C_ILL && TRAP_EN == 0);
            end
            S_JUMP: begin
               PCWrite    = 1'b1;
               PCSource   = 2'b10;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 2'b01;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               instr_done  = 1'b1;
               cond_sel    = (cls_q == C_BNE) ? 2'b01 : (cls_q == C_BLT) ? 2'b10 : 2'b00;
            end
            S_EXEC_R: begin
               ALUSrcA = 2'b01;
               ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
            end
            S_EXEC_LUI: begin
               ALUSrcB = 2'b11;
               ALUOp   = 2'b11;
            end
            S_WB_ALU: begin
               RegWrite   = 1'b1;
               RegSelect2 = (cls_q == C_R) ? 2'b00 : 2'b01;
               instr_done = 1'b1;
            end
            S_ADDR: begin
               ALUSrcB = 2'b10;
               ALUSrcA = (cls_q == C_LWI || cls_q == C_SWI) ? 2'b10 : 2'b01;
            end
            S_MEM_RD: mem_req = 1'b1;
            S_MEM_WR: begin
               mem_req    = 1'b1;
               MemWrite   = 1'b1;
               instr_done = rdy_c;
            end
            S_WB_MEM: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               RegSelect2 = 2'b01;
               instr_done = 1'b1;
            end
            S_TRAP: begin
               illegal    = 1'b1;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_hs.sv
// Scoreboard bench for mc_control_hs: a driver applies per-cycle stimulus and
// queues the spec-derived expected outputs; a monitor pops and compares each cycle.
module tb_mc_control_hs;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       mem_req, PCWrite, PCWriteCond, MemWrite, MemtoReg, IRWrite;
   logic       RegWrite, illegal, instr_done;
   logic [1:0] cond_sel, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegSelect2;
   logic [3:0] state;

   mc_control_hs #(.OPW(6), .MEM_HS(1), .TRAP_EN(1)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .cond_sel(cond_sel), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .RegSelect2(RegSelect2),
      .illegal(illegal), .instr_done(instr_done), .state(state)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] st;
      logic       mreq, pcw, pcwc;
      logic [1:0] cs;
      logic       mw, m2r, irw;
      logic [1:0] pcs, aluop, asa, asb;
      logic       rw;
      logic [1:0] rs2;
      logic       ill, done;
   } exp_t;

   localparam int K_NOOP = 0, K_J = 1, K_BEQ = 2, K_BNE = 3, K_BLT = 4, K_R = 5,
                  K_I = 6, K_LUI = 7, K_LW = 8, K_SW = 9, K_LWI = 10, K_SWI = 11,
                  K_ILL = 12;

   exp_t sbq[$];
   int   ncmp = 0;
   int   nerr = 0;

   function automatic int kind(input logic [5:0] op);
      case (op)
         6'b000000: return K_NOOP;
         6'b000001: return K_J;
         6'b100000: return K_BEQ;
         6'b100001: return K_BNE;
         6'b100010: return K_BLT;
         6'b010101: return K_R;
         6'b110010: return K_I;
         6'b111010: return K_LUI;
         6'b111101: return K_LW;
         6'b111110: return K_SW;
         6'b111011: return K_LWI;
         6'b111100: return K_SWI;
         default:   return K_ILL;
      endcase
   endfunction

   // Monitor: compare DUT outputs with the oldest queued expectation each cycle
   always @(negedge clock) begin
      exp_t e, a;
      #2;
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         a = '{state, mem_req, PCWrite, PCWriteCond, cond_sel, MemWrite, MemtoReg,
               IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegSelect2,
               illegal, instr_done};
         ncmp++;
         if (a !== e) begin
            nerr++;
            $display("FAIL cycle_outputs t=%0t got=%h expected=%h (state got %0d exp %0d)",
                     $time, a, e, a.st, e.st);
         end
      end
   end

   // Apply one cycle of stimulus and queue its expected outputs
   task automatic cyc(input logic [5:0] op, input logic mr, input logic rs, input exp_t e);
      @(negedge clock);
      opcode    = op;
      mem_ready = mr;
      reset     = rs;
      sbq.push_back(e);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom);
   endfunction

   // Reference model of one instruction; rst_mem pulses reset after the store waits
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit rst_mem);
      exp_t e;
      int   k;
      k = kind(op);
      for (int i = 0; i < fw; i++) begin
         e = '0; e.mreq = 1'b1; e.asb = 2'b01;
         cyc(op, 1'b0, 1'b1, e);
      end
      e = '0; e.mreq = 1'b1; e.asb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
      cyc(op, 1'b1, 1'b1, e);
      e = '0; e.st = 4'd1; e.asb = 2'b10; e.done = (k == K_NOOP);
      cyc(op, rb(), 1'b1, e);
      case (k)
         K_J: begin
            e = '0; e.st = 4'd6; e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1;
            cyc(rop(), rb(), 1'b1, e);
         end
         K_BEQ, K_BNE, K_BLT: begin
            e = '0; e.st = 4'd5; e.asa = 2'b01; e.aluop = 2'b01; e.pcwc = 1'b1;
            e.pcs = 2'b01; e.done = 1'b1;
            e.cs = (k == K_BNE) ? 2'b01 : (k == K_BLT) ? 2'b10 : 2'b00;
            cyc(rop(), rb(), 1'b1, e);
         end
         K_R, K_I, K_LUI: begin
            e = '0;
            if (k == K_R)   begin e.st = 4'd2; e.asa = 2'b01; e.aluop = 2'b10; end
            if (k == K_I)   begin e.st = 4'd3; e.asa = 2'b01; e.asb = 2'b10; end
            if (k == K_LUI) begin e.st = 4'd4; e.asb = 2'b11; e.aluop = 2'b11; end
            cyc(rop(), rb(), 1'b1, e);
            e = '0; e.st = 4'd10; e.rw = 1'b1; e.done = 1'b1;
            e.rs2 = (k == K_R) ? 2'b00 : 2'b01;
            cyc(rop(), rb(), 1'b1, e);
         end
         K_LW, K_SW, K_LWI, K_SWI: begin
            e = '0; e.st = 4'd7; e.asb = 2'b10;
            e.asa = (k == K_LWI || k == K_SWI) ? 2'b10 : 2'b01;
            cyc(rop(), rb(), 1'b1, e);
            if (k == K_LW || k == K_LWI) begin
               for (int i = 0; i <= mw; i++) begin
                  e = '0; e.st = 4'd8; e.mreq = 1'b1;
                  cyc(rop(), (i == mw), 1'b1, e);
               end
               e = '0; e.st = 4'd11; e.rw = 1'b1; e.m2r = 1'b1; e.rs2 = 2'b01; e.done = 1'b1;
               cyc(rop(), rb(), 1'b1, e);
            end else begin
               for (int i = 0; i < mw; i++) begin
                  e = '0; e.st = 4'd9; e.mreq = 1'b1; e.mw = 1'b1;
                  cyc(rop(), 1'b0, 1'b1, e);
               end
               if (rst_mem) begin
                  e = '0;
                  cyc(rop(), 1'b1, 1'b0, e);
               end else begin
                  e = '0; e.st = 4'd9; e.mreq = 1'b1; e.mw = 1'b1; e.done = 1'b1;
                  cyc(rop(), 1'b1, 1'b1, e);
               end
            end
         end
         K_ILL: begin
            e = '0; e.st = 4'd12; e.ill = 1'b1; e.done = 1'b1;
            cyc(rop(), rb(), 1'b1, e);
         end
         default: ;
      endcase
   endtask

   logic [5:0] legal [12] = '{6'b000000, 6'b000001, 6'b100000, 6'b100001, 6'b100010,
                              6'b010101, 6'b110010, 6'b111010, 6'b111101, 6'b111110,
                              6'b111011, 6'b111100};

   initial begin
      exp_t z;
      logic [5:0] op;
      z = '0;
      // Reset held low: all outputs zero, state FETCH
      for (int i = 0; i < 3; i++) cyc(6'b000001, 1'b1, 1'b0, z);
      run_instr(6'b000001, 0, 0, 1'b0);   // J
      run_instr(6'b100001, 0, 0, 1'b0);   // BNE
      run_instr(6'b100010, 0, 0, 1'b0);   // BLT
      run_instr(6'b111101, 2, 3, 1'b0);   // LW with waits
      run_instr(6'b111100, 0, 2, 1'b0);   // SWI
      run_instr(6'b111110, 1, 1, 1'b0);   // SW
      run_instr(6'b110010, 0, 0, 1'b0);   // ADDI
      run_instr(6'b111010, 0, 0, 1'b0);   // LUI
      run_instr(6'b010101, 0, 0, 1'b0);   // AND
      run_instr(6'b011111, 0, 0, 1'b0);   // illegal -> TRAP
      run_instr(6'b111110, 0, 1, 1'b1);   // SW interrupted by reset in MEM_WR
      run_instr(6'b000000, 0, 0, 1'b0);   // NOOP after reset release
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 7) == 0) op = rop();
         else                           op = legal[$urandom_range(0, 11)];
         run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 15) == 0));
      end
      repeat (2) @(negedge clock);
      #4;
      ncmp++;
      if (sbq.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain left=%0d required=0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
      $finish;
   end

endmodule
